// File: rtl/ptrain_pkg.sv
// Shared types and helpers for the perceptron training engine: FSM state
// encoding, saturating add and the accumulator sizing rule.
package ptrain_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT      = 3'd1,
        S_REQ       = 3'd2,
        S_MAC       = 3'd3,
        S_EVAL      = 3'd4,
        S_UPDATE    = 3'd5,
        S_EPOCH_END = 3'd6
    } ptrain_state_e;

    // Add two signed values and clamp the sum to a dw-bit signed range.
    function automatic int sat_dw(input int a, input int b, input int dw);
        int sum_v;
        int hi_v;
        int lo_v;
        sum_v = a + b;
        hi_v  = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo_v  = -hi_v - 32'sd1;
        if (sum_v > hi_v) begin
            return hi_v;
        end else if (sum_v < lo_v) begin
            return lo_v;
        end else begin
            return sum_v;
        end
    endfunction

    // Smallest accumulator that cannot overflow over n_in products plus bias.
    function automatic int min_acc_width(input int dw, input int n_in);
        return 2 * dw + $clog2(n_in + 1);
    endfunction

endpackage

// File: rtl/ptrain_mac.sv
// Sequential multiply-accumulate: one x[k]*w[k] product per step, accumulator
// preloaded with the sign-extended bias on clear.
module ptrain_mac #(
    parameter int N_IN = 2,
    parameter int DW   = 8,
    parameter int AW   = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 step,
    input  logic [N_IN*DW-1:0]   x,
    input  logic [N_IN*DW-1:0]   w,
    input  logic [DW-1:0]        bias,
    output logic                 acc_neg,
    output logic                 last_idx
);
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic [IW-1:0]          idx_r;
    logic signed [AW-1:0]   acc_r;
    logic [DW-1:0]          xk_s;
    logic [DW-1:0]          wk_s;
    logic [2*DW-1:0]        prod_s;

    // Operand select for the current index and full-width signed product.
    always_comb begin
        xk_s = '0;
        wk_s = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (idx_r == IW'(i)) begin
                xk_s = x[i*DW +: DW];
                wk_s = w[i*DW +: DW];
            end else begin
                xk_s = xk_s;
                wk_s = wk_s;
            end
        end
        // Operands are sign-extended to 2*DW so the low half of the product is exact.
        prod_s = {{DW{xk_s[DW-1]}}, xk_s} * {{DW{wk_s[DW-1]}}, wk_s};
    end

    // Index counter and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r <= '0;
            acc_r <= '0;
        end else if (clear) begin
            idx_r <= '0;
            acc_r <= {{(AW-DW){bias[DW-1]}}, bias};
        end else if (step) begin
            idx_r <= idx_r + IW'(1);
            acc_r <= acc_r + {{(AW-2*DW){prod_s[2*DW-1]}}, prod_s};
        end else begin
            idx_r <= idx_r;
            acc_r <= acc_r;
        end
    end

    assign acc_neg  = acc_r[AW-1];
    assign last_idx = (idx_r == IW'(N_IN - 1));

endmodule

// File: rtl/perceptron_trainer.sv
// N-input perceptron training engine (FSM + datapath). Optional PTRAIN_WINIT_EN
// adds w_init/b_init ports loaded in INIT instead of clearing to zero.
module perceptron_trainer
    import ptrain_pkg::*;
#(
    parameter int N_IN      = 2,
    parameter int DW        = 8,
    parameter int AW        = 20,
    parameter int MAX_EPOCH = 16,
    parameter int LR_SHIFT  = 0,
    parameter int EW        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef PTRAIN_WINIT_EN
    input  logic [N_IN*DW-1:0]   w_init,
    input  logic [DW-1:0]        b_init,
`endif
    input  logic                 start,
    output logic                 sample_req,
    input  logic                 sample_valid,
    input  logic [N_IN*DW-1:0]   sample_x,
    input  logic                 sample_t,
    input  logic                 sample_last,
    output logic                 busy,
    output logic                 done,
    output logic                 converged,
    output logic [EW-1:0]        epoch_cnt,
    output logic [EW-1:0]        err_cnt,
    output logic [N_IN*DW-1:0]   weights,
    output logic [DW-1:0]        bias
);
    localparam int MIN_AW = min_acc_width(DW, N_IN);

    if (AW < MIN_AW) begin : g_aw_check
        $error("perceptron_trainer: AW too small for DW/N_IN");
    end

    ptrain_state_e        state_r, state_nx_s;
    logic [N_IN*DW-1:0]   w_r, w_upd_s, x_r;
    logic [DW-1:0]        b_r, b_upd_s;
    logic                 t_r, last_r;
    logic [EW-1:0]        epoch_r, err_r;
    logic                 done_r, conv_r;
    logic                 mac_clear_s, mac_step_s, acc_neg_s, mac_last_s;
    logic                 mispredict_s, epoch_lim_s;

    ptrain_mac #(.N_IN(N_IN), .DW(DW), .AW(AW)) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clear    (mac_clear_s),
        .step     (mac_step_s),
        .x        (x_r),
        .w        (w_r),
        .bias     (b_r),
        .acc_neg  (acc_neg_s),
        .last_idx (mac_last_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode and MAC control strobes.
    always_comb begin
        state_nx_s   = state_r;
        mac_clear_s  = 1'b0;
        mac_step_s   = 1'b0;
        // acc<0 means y=-1, so a mismatch is exactly acc_neg == t.
        mispredict_s = (acc_neg_s == t_r);
        epoch_lim_s  = ((epoch_r + EW'(1)) == EW'(MAX_EPOCH));
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nx_s = S_INIT;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_INIT: state_nx_s = S_REQ;
            S_REQ: begin
                if (sample_valid) begin
                    mac_clear_s = 1'b1;
                    state_nx_s  = S_MAC;
                end else begin
                    state_nx_s  = S_REQ;
                end
            end
            S_MAC: begin
                mac_step_s = 1'b1;
                if (mac_last_s) begin
                    state_nx_s = S_EVAL;
                end else begin
                    state_nx_s = S_MAC;
                end
            end
            S_EVAL: begin
                if (mispredict_s) begin
                    state_nx_s = S_UPDATE;
                end else if (last_r) begin
                    state_nx_s = S_EPOCH_END;
                end else begin
                    state_nx_s = S_REQ;
                end
            end
            S_UPDATE: begin
                if (last_r) begin
                    state_nx_s = S_EPOCH_END;
                end else begin
                    state_nx_s = S_REQ;
                end
            end
            S_EPOCH_END: begin
                if ((err_r == '0) || epoch_lim_s) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_REQ;
                end
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Saturating perceptron update of every weight and the bias.
    always_comb begin
        int d_v;
        int s_v;
        w_upd_s = '0;
        for (int i = 0; i < N_IN; i++) begin
            d_v = int'($signed(x_r[i*DW +: DW])) >>> LR_SHIFT;
            if (!t_r) begin
                d_v = -d_v;
            end else begin
                d_v = d_v;
            end
            s_v = sat_dw(int'($signed(w_r[i*DW +: DW])), d_v, DW);
            w_upd_s[i*DW +: DW] = s_v[DW-1:0];
        end
        s_v = sat_dw(int'($signed(b_r)), t_r ? 32'sd1 : -32'sd1, DW);
        b_upd_s = s_v[DW-1:0];
    end

    // Datapath registers: sample latch, weights, counters and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_r     <= '0;
            b_r     <= '0;
            x_r     <= '0;
            t_r     <= 1'b0;
            last_r  <= 1'b0;
            epoch_r <= '0;
            err_r   <= '0;
            done_r  <= 1'b0;
            conv_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_INIT: begin
`ifdef PTRAIN_WINIT_EN
                    w_r <= w_init;
                    b_r <= b_init;
`else
                    w_r <= '0;
                    b_r <= '0;
`endif
                    epoch_r <= '0;
                    err_r   <= '0;
                    conv_r  <= 1'b0;
                end
                S_REQ: begin
                    if (sample_valid) begin
                        x_r    <= sample_x;
                        t_r    <= sample_t;
                        last_r <= sample_last;
                    end else begin
                        x_r    <= x_r;
                    end
                end
                S_UPDATE: begin
                    w_r <= w_upd_s;
                    b_r <= b_upd_s;
                    if (err_r != {EW{1'b1}}) begin
                        err_r <= err_r + EW'(1);
                    end else begin
                        err_r <= err_r;
                    end
                end
                S_EPOCH_END: begin
                    epoch_r <= epoch_r + EW'(1);
                    if (err_r == '0) begin
                        conv_r <= 1'b1;
                        done_r <= 1'b1;
                    end else if (epoch_lim_s) begin
                        done_r <= 1'b1;
                    end else begin
                        err_r  <= '0;
                    end
                end
                default: begin
                    w_r <= w_r;
                end
            endcase
        end
    end

    assign sample_req = (state_r == S_REQ);
    assign busy       = (state_r != S_IDLE);
    assign done       = done_r;
    assign converged  = conv_r;
    assign epoch_cnt  = epoch_r;
    assign err_cnt    = err_r;
    assign weights    = w_r;
    assign bias       = b_r;

endmodule
